vec_issue_sequencer: RTL and testbench

//  Sits between fetch-regs and the four exec_to_wb pipes. Latches one decoded op with
//  its operand values and splits 256-bit vector operands into 4-lane beats, one lane
//  per pipe per beat. Stalls the upstream stage until the last beat is accepted.
//  A scalar op is issued as a single beat on pipe 0.

---
 rtl/vec_issue_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_vec_issue_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_sequencer.sv
// Vector issue sequencer: holds one decoded op and streams its operands to the
// exec pipes as NPIPE-lane beats; a scalar op is a single lane-0 beat.
module vec_issue_sequencer #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int NPIPE  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_pc,
    input  logic [3:0]                in_opcode,
    input  logic [3:0]                in_rt,
    input  logic                      in_scalar,
    input  logic [4:0]                in_len,
    input  logic [LANES*LANE_W-1:0]   in_va,
    input  logic [LANES*LANE_W-1:0]   in_vb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NPIPE-1:0]          out_lane_en,
    output logic [NPIPE*LANE_W-1:0]   out_a,
    output logic [NPIPE*LANE_W-1:0]   out_b,
    output logic [1:0]                out_group,
    output logic                      out_last,
    output logic [15:0]               out_pc,
    output logic [3:0]                out_opcode,
    output logic [3:0]                out_rt
);
    localparam int LEN_W = 5;
    localparam int GRP_W = 2;
    localparam int VEC_W = LANES * LANE_W;
    localparam int BEAT_W = NPIPE * LANE_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]         state_r,   state_s;
    logic [VEC_W-1:0]   va_r,      va_s;
    logic [VEC_W-1:0]   vb_r,      vb_s;
    logic [LEN_W-1:0]   len_r,     len_s;
    logic               valid_r,   valid_s;
    logic [NPIPE-1:0]   lane_en_r, lane_en_s;
    logic [BEAT_W-1:0]  a_r,       a_s;
    logic [BEAT_W-1:0]  b_r,       b_s;
    logic [GRP_W-1:0]   group_r,   group_s;
    logic               last_r,    last_s;
    logic [15:0]        pc_r,      pc_s;
    logic [3:0]         opcode_r,  opcode_s;
    logic [3:0]         rt_r,      rt_s;

    logic [LEN_W-1:0]   eff_len_s;
    logic               ready_s, load_s, step_s, done_s;
    logic [VEC_W-1:0]   src_va_s, src_vb_s;
    logic [LEN_W-1:0]   src_len_s;
    logic [GRP_W-1:0]   src_grp_s;

    function automatic logic [NPIPE-1:0] lane_en_f(input logic [LEN_W-1:0] len,
                                                   input logic [GRP_W-1:0] grp);
        lane_en_f = {NPIPE{1'b0}};
        for (int i = 0; i < NPIPE; i++) begin
            lane_en_f[i] = ((int'(grp) * NPIPE + i) < int'(len));
        end
    endfunction

    // Disabled pipes carry zero so downstream never sees stale lanes.
    function automatic logic [BEAT_W-1:0] lanes_f(input logic [VEC_W-1:0] vec,
                                                  input logic [LEN_W-1:0] len,
                                                  input logic [GRP_W-1:0] grp);
        int idx;
        lanes_f = {BEAT_W{1'b0}};
        for (int i = 0; i < NPIPE; i++) begin
            idx = int'(grp) * NPIPE + i;
            if (idx < int'(len)) begin
                lanes_f[i*LANE_W +: LANE_W] = vec[idx*LANE_W +: LANE_W];
            end else begin
                lanes_f[i*LANE_W +: LANE_W] = {LANE_W{1'b0}};
            end
        end
    endfunction

    function automatic logic last_f(input logic [LEN_W-1:0] len,
                                    input logic [GRP_W-1:0] grp);
        last_f = (int'(grp) == ((int'(len) + NPIPE - 1) / NPIPE) - 1);
    endfunction

    // Handshake decode and selection of the operand source for the next beat.
    always_comb begin
        eff_len_s = in_scalar ? 5'd1 : ((in_len > 5'd16) ? 5'd16 : in_len);
        ready_s   = !flush && ((state_r == ST_IDLE) || (valid_r && out_ready && last_r));
        load_s    = in_valid && ready_s && (eff_len_s != 5'd0);
        step_s    = (state_r == ST_ISSUE) && out_ready && !last_r;
        done_s    = (state_r == ST_ISSUE) && out_ready && last_r;
        if (load_s) begin
            src_va_s  = in_va;
            src_vb_s  = in_vb;
            src_len_s = eff_len_s;
            src_grp_s = 2'd0;
        end else begin
            src_va_s  = va_r;
            src_vb_s  = vb_r;
            src_len_s = len_r;
            src_grp_s = group_r + 2'd1;
        end
    end

    // Next-state: flush beats everything, then a new op, then beat advance/retire.
    always_comb begin
        state_s   = state_r;
        va_s      = va_r;
        vb_s      = vb_r;
        len_s     = len_r;
        valid_s   = valid_r;
        lane_en_s = lane_en_r;
        a_s       = a_r;
        b_s       = b_r;
        group_s   = group_r;
        last_s    = last_r;
        pc_s      = pc_r;
        opcode_s  = opcode_r;
        rt_s      = rt_r;
        if (flush || (done_s && !load_s)) begin
            state_s   = ST_IDLE;
            len_s     = 5'd0;
            valid_s   = 1'b0;
            lane_en_s = {NPIPE{1'b0}};
            a_s       = {BEAT_W{1'b0}};
            b_s       = {BEAT_W{1'b0}};
            group_s   = 2'd0;
            last_s    = 1'b0;
            pc_s      = 16'd0;
            opcode_s  = 4'd0;
            rt_s      = 4'd0;
        end else if (load_s || step_s) begin
            state_s   = ST_ISSUE;
            va_s      = src_va_s;
            vb_s      = src_vb_s;
            len_s     = src_len_s;
            valid_s   = 1'b1;
            lane_en_s = lane_en_f(src_len_s, src_grp_s);
            a_s       = lanes_f(src_va_s, src_len_s, src_grp_s);
            b_s       = lanes_f(src_vb_s, src_len_s, src_grp_s);
            group_s   = src_grp_s;
            last_s    = last_f(src_len_s, src_grp_s);
            if (load_s) begin
                pc_s     = in_pc;
                opcode_s = in_opcode;
                rt_s     = in_rt;
            end else begin
                pc_s     = pc_r;
                opcode_s = opcode_r;
                rt_s     = rt_r;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            va_r      <= {VEC_W{1'b0}};
            vb_r      <= {VEC_W{1'b0}};
            len_r     <= 5'd0;
            valid_r   <= 1'b0;
            lane_en_r <= {NPIPE{1'b0}};
            a_r       <= {BEAT_W{1'b0}};
            b_r       <= {BEAT_W{1'b0}};
            group_r   <= 2'd0;
            last_r    <= 1'b0;
            pc_r      <= 16'd0;
            opcode_r  <= 4'd0;
            rt_r      <= 4'd0;
        end else begin
            state_r   <= state_s;
            va_r      <= va_s;
            vb_r      <= vb_s;
            len_r     <= len_s;
            valid_r   <= valid_s;
            lane_en_r <= lane_en_s;
            a_r       <= a_s;
            b_r       <= b_s;
            group_r   <= group_s;
            last_r    <= last_s;
            pc_r      <= pc_s;
            opcode_r  <= opcode_s;
            rt_r      <= rt_s;
        end
    end

    assign in_ready    = ready_s;
    assign out_valid   = valid_r;
    assign out_lane_en = lane_en_r;
    assign out_a       = a_r;
    assign out_b       = b_r;
    assign out_group   = group_r;
    assign out_last    = last_r;
    assign out_pc      = pc_r;
    assign out_opcode  = opcode_r;
    assign out_rt      = rt_r;
endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Randomized bench for vec_issue_sequencer against a transaction-level model
// that tracks the held op and its current beat number.
module tb_vec_issue_sequencer;
    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_pc;
    logic [3:0]   in_opcode;
    logic [3:0]   in_rt;
    logic         in_scalar;
    logic [4:0]   in_len;
    logic [255:0] in_va;
    logic [255:0] in_vb;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_lane_en;
    logic [63:0]  out_a;
    logic [63:0]  out_b;
    logic [1:0]   out_group;
    logic         out_last;
    logic [15:0]  out_pc;
    logic [3:0]   out_opcode;
    logic [3:0]   out_rt;

    vec_issue_sequencer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_opcode(in_opcode), .in_rt(in_rt),
        .in_scalar(in_scalar), .in_len(in_len), .in_va(in_va), .in_vb(in_vb),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
        .out_a(out_a), .out_b(out_b), .out_group(out_group), .out_last(out_last),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rt(out_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the op in flight and which beat of it is on the outputs.
    bit           busy;
    int           m_len;
    int           m_beat;
    logic [255:0] m_va, m_vb;
    logic [15:0]  m_pc;
    logic [3:0]   m_op, m_rt;
    bit           exp_rdy;
    bit           did_rst;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int eff_len(input bit sc, input int len);
        if (sc) return 1;
        return (len > 16) ? 16 : len;
    endfunction

    function automatic int nbeats(input int len);
        return (len + 3) / 4;
    endfunction

    task automatic check_idle_zero();
        check_val("rst_valid",   64'(out_valid),   64'd0);
        check_val("rst_lane_en", 64'(out_lane_en), 64'd0);
        check_val("rst_a",       out_a,            64'd0);
        check_val("rst_b",       out_b,            64'd0);
        check_val("rst_group",   64'(out_group),   64'd0);
        check_val("rst_last",    64'(out_last),    64'd0);
        check_val("rst_pc",      64'(out_pc),      64'd0);
        check_val("rst_opcode",  64'(out_opcode),  64'd0);
        check_val("rst_rt",      64'(out_rt),      64'd0);
        check_val("rst_ready",   64'(in_ready),    64'd1);
    endtask

    task automatic check_outputs();
        logic [3:0]  e_en;
        logic [63:0] e_a, e_b;
        int          lane;
        check_val("valid", 64'(out_valid), 64'(busy));
        if (busy) begin
            e_en = 4'd0;
            e_a  = 64'd0;
            e_b  = 64'd0;
            for (int i = 0; i < 4; i++) begin
                lane = 4 * m_beat + i;
                if (lane < m_len) begin
                    e_en[i]        = 1'b1;
                    e_a[16*i +: 16] = m_va[16*lane +: 16];
                    e_b[16*i +: 16] = m_vb[16*lane +: 16];
                end
            end
            check_val("group",   64'(out_group),   64'(m_beat));
            check_val("last",    64'(out_last),    64'(m_beat == nbeats(m_len) - 1));
            check_val("lane_en", 64'(out_lane_en), 64'(e_en));
            check_val("a",       out_a,            e_a);
            check_val("b",       out_b,            e_b);
            check_val("pc",      64'(out_pc),      64'(m_pc));
            check_val("opcode",  64'(out_opcode),  64'(m_op));
            check_val("rt",      64'(out_rt),      64'(m_rt));
        end
    endtask

    task automatic drive_random();
        int pick, lenv;
        flush     = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = ($urandom_range(0, 2) != 0);
        in_scalar = ($urandom_range(0, 7) == 0);
        pick      = int'($urandom_range(0, 7));
        case (pick)
            0:       lenv = 0;
            1:       lenv = 5;
            2:       lenv = 16;
            3:       lenv = 20;
            4:       lenv = 31;
            default: lenv = int'($urandom_range(0, 31));
        endcase
        in_len    = 5'(lenv);
        in_pc     = 16'($urandom());
        in_opcode = 4'($urandom());
        in_rt     = 4'($urandom());
        for (int w = 0; w < 8; w++) begin
            in_va[32*w +: 32] = $urandom();
            in_vb[32*w +: 32] = $urandom();
        end
    endtask

    task automatic model_update();
        bit fire_last;
        int el;
        if (flush) begin
            busy = 1'b0;
        end else begin
            fire_last = busy && out_ready && (m_beat == nbeats(m_len) - 1);
            if (fire_last) busy = 1'b0;
            else if (busy && out_ready) m_beat++;
            el = eff_len(in_scalar, int'(in_len));
            if (in_valid && exp_rdy && el != 0) begin
                busy   = 1'b1;
                m_beat = 0;
                m_len  = el;
                m_va   = in_va;
                m_vb   = in_vb;
                m_pc   = in_pc;
                m_op   = in_opcode;
                m_rt   = in_rt;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 16'd0; in_opcode = 4'd0; in_rt = 4'd0; in_scalar = 1'b0;
        in_len = 5'd0; in_va = 256'd0; in_vb = 256'd0;
        busy = 1'b0; m_len = 0; m_beat = 0; did_rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero();
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            // One asynchronous reset in the middle of a running op.
            if (!did_rst && cyc > 2000 && busy && m_beat > 0) begin
                did_rst = 1'b1;
                flush   = 1'b0;
                rst_n   = 1'b0;
                #1;
                check_idle_zero();
                busy = 1'b0;
                #1 rst_n = 1'b1;
            end
            check_outputs();
            drive_random();
            exp_rdy = !flush && (!busy || (out_ready && m_beat == nbeats(m_len) - 1));
            #1;
            check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
            @(posedge clk);
            model_update();
        end
        check_val("mid_op_reset_seen", 64'(did_rst), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
